// File: rtl/rptr_empty_handler.sv
// Read-domain pointer, empty/almost_empty and occupancy tracking for an async FIFO.
// Build option: define RPTR_UNDERFLOW_STICKY_EN to hold underflow high until rrst.
module rptr_empty_handler #(
    parameter int PTR_WIDTH     = 8,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 r_en,
    input  logic [PTR_WIDTH:0]   g_wptr_sync,
    output logic [PTR_WIDTH:0]   b_rptr,
    output logic [PTR_WIDTH:0]   g_rptr,
    output logic [PTR_WIDTH-1:0] raddr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   rd_count,
    output logic                 rd_valid,
    output logic                 underflow
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AE_TH = PW'(AEMPTY_THRESH);

    // Handshake: r_en is a request; it transfers only when empty is low in the
    // same cycle (accept). Read data is valid one cycle later, flagged by rd_valid.
    logic               accept;
    logic [PTR_WIDTH:0] b_rptr_next;
    logic [PTR_WIDTH:0] g_rptr_next;
    logic [PTR_WIDTH:0] b_wsync;
    logic [PTR_WIDTH:0] rd_count_next;
    logic               underflow_next;

    always_comb begin
        accept      = r_en & ~empty;
        b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, accept};
        g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;

        // Each binary bit is the XOR of all Gray bits at or above it.
        b_wsync = '0;
        for (int i = 0; i < PW; i++) begin
            b_wsync[i] = ^(g_wptr_sync >> i);
        end

        rd_count_next = b_wsync - b_rptr_next;

`ifdef RPTR_UNDERFLOW_STICKY_EN
        underflow_next = underflow | (r_en & empty);
`else
        underflow_next = r_en & empty;
`endif
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            rd_valid     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            b_rptr       <= b_rptr_next;
            g_rptr       <= g_rptr_next;
            empty        <= (g_rptr_next == g_wptr_sync);
            almost_empty <= (rd_count_next <= AE_TH);
            rd_count     <= rd_count_next;
            rd_valid     <= accept;
            underflow    <= underflow_next;
        end
    end

    assign raddr = b_rptr[PTR_WIDTH-1:0];

endmodule
